lstm_sequencer: RTL and testbench
=================================

LSTM_SEQUENCER -- requirements
Module: lstm_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: signed Q8.8 data width shared with the LSTM cell.
REQ-002 Parameter DEPTH, default 8: input FIFO entries; power of 2, at least 2.
REQ-003 Parameter LEN_W, default 8: width of the sequence-length field.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 seq_len  in  LEN_W  timesteps per sequence; 0 is treated as 1.
REQ-007 h_init, C_init  in  WIDTH each  initial hidden and cell state for each sequence.
REQ-008 s_data  in  WIDTH;  s_valid  in  1;  s_ready  out  1  input sample stream.
REQ-009 cell_ready  in  1  ready from the downstream LSTM cell.
REQ-010 cell_x, cell_h, cell_C  out  WIDTH each  operands driven to the cell.
REQ-011 cell_x_valid, cell_h_valid, cell_C_valid  out  1 each  operand strobes.
REQ-012 cell_y, cell_C_out  in  WIDTH each;  cell_valid  in  1  cell results.
REQ-013 m_y, m_C  out  WIDTH each;  m_valid  out  1;  m_last  out  1;  m_ready  in  1  result stream.

Function
REQ-014 Input FIFO: holds DEPTH entries; s_ready = not full; a sample is written when s_valid and s_ready are both high; a written sample can be issued no earlier than the next cycle.
REQ-015 FSM states:
- IDLE -> ISSUE when the FIFO is non-empty and the output buffer has space.
- ISSUE -> WAIT on an issue cycle.
- WAIT -> ISSUE on cell_valid when the sequence is not yet complete.
- WAIT -> IDLE on cell_valid when the sequence is complete.
REQ-016 An issue cycle SHALL satisfy all of: state ISSUE, FIFO non-empty, cell_ready=1, (output occupancy + in-flight) < 2.
- On an issue cycle, cell_x_valid pulses for exactly one cycle with cell_x = FIFO head, and the FIFO pops.
- If the FIFO is empty in ISSUE, the FSM stalls in ISSUE with no pulse.
REQ-017 The first issue of a sequence (step counter = 0) SHALL also pulse cell_h_valid and cell_C_valid, carrying h_init and C_init; later issues keep both strobes at 0 so the cell uses its internal feedback.
REQ-018 seq_len is latched at the first issue of each sequence; changes mid-sequence have no effect.
REQ-019 The step counter increments on each issue; the sequence is complete once the counter equals the latched length; the counter clears when the FSM enters IDLE.
REQ-020 At most one sample is in flight; in-flight sets on issue and clears on cell_valid.
- cell_valid while not in flight is ignored.
- cell_valid in the same cycle as an issue is impossible by construction; the bench asserts it never occurs.
REQ-021 Output buffer: 2 entries. On cell_valid it captures {cell_y, cell_C_out, last}, where last = 1 for the final step of the sequence. The entry appears on m_* the following cycle.
REQ-022 Output handshake: an entry pops when m_valid and m_ready are both high; m_y/m_C/m_last stay stable while m_valid=1 and m_ready=0. Push and pop in the same cycle leave occupancy unchanged.
REQ-023 Latency: s_data accepted at cycle T, FIFO empty, cell idle, then:
- issue at T+1;
- m_valid at T+1+L+1, where L is the cell latency (6).
REQ-024 Throughput: one sample per (L+1) cycles at best; backpressure on m_ready throttles issue and never drops a result.
REQ-025 Arithmetic: none; all data passes through unmodified at WIDTH bits, signed.

Reset
REQ-026 While rst is high, and asynchronously on its assertion:
- FSM in IDLE; step counter, in-flight flag, FIFO and output pointers cleared;
- s_ready=0; cell_*_valid=0; m_valid=0; m_last=0;
- data outputs 0.
REQ-027 s_ready rises on the first clock edge after rst deasserts. Reset mid-sequence discards all queued and in-flight data, and a subsequent cell_valid is ignored.

Verification (bench provides a cell model: L=6, cell_ready low while busy, y = x+h, C_out = x+C)
REQ-028 seq_len=3, h_init=0x0010, C_init=0x0020, inputs 0x0100, 0x0200, 0x0300, m_ready=1 -> h/C strobes on issue 1 only; three m_valid beats; m_last only on the third; first m_y=0x0110.
REQ-029 Write DEPTH+1 samples back-to-back with no issue (cell_ready=0) -> s_ready drops after DEPTH writes; the extra sample is not accepted; no data lost once cell_ready=1.
REQ-030 m_ready=0, seq_len=4 -> exactly 2 results buffered, then no further issue; raising m_ready releases the remaining results in order.
REQ-031 seq_len=0 -> sequence of length 1; m_last=1 on the single result; the next sample re-pulses h/C strobes.
REQ-032 Assert rst during WAIT, then release and feed a new sequence -> all outputs at reset values; the stale cell_valid is ignored; the new sequence starts at step 0 with h/C strobes.
REQ-033 Change seq_len from 2 to 5 after the first issue -> the sequence still ends after 2 results.

Source files
------------

// File: rtl/lstm_sequencer.sv
// Feeds a sample stream through an external LSTM cell one timestep at a time,
// injecting h/C initial state at each sequence start and buffering results.
module lstm_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic        [LEN_W-1:0] seq_len,
    input  logic signed [WIDTH-1:0] h_init,
    input  logic signed [WIDTH-1:0] C_init,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    cell_ready,
    output logic signed [WIDTH-1:0] cell_x,
    output logic signed [WIDTH-1:0] cell_h,
    output logic signed [WIDTH-1:0] cell_C,
    output logic                    cell_x_valid,
    output logic                    cell_h_valid,
    output logic                    cell_C_valid,
    input  logic signed [WIDTH-1:0] cell_y,
    input  logic signed [WIDTH-1:0] cell_C_out,
    input  logic                    cell_valid,
    output logic signed [WIDTH-1:0] m_y,
    output logic signed [WIDTH-1:0] m_C,
    output logic                    m_valid,
    output logic                    m_last,
    input  logic                    m_ready
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t            state_q, state_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  fifo_mem [DEPTH];
    logic              live_q;
    logic [LEN_W-1:0]  step_q, step_d, len_q, len_d;
    logic              inflight_q, inflight_d;
    logic [WIDTH-1:0]  ob_y_q [2];
    logic [WIDTH-1:0]  ob_c_q [2];
    logic              ob_last_q [2];
    logic [1:0]        ob_cnt_q, ob_cnt_d;
    logic              ob_wr_q, ob_wr_d, ob_rd_q, ob_rd_d;

    logic              fifo_full, fifo_empty, wr_en, room, issue, first, hc_fire;
    logic              accept, done, pop;
    logic [LEN_W-1:0]  len_eff;
    logic [WIDTH-1:0]  head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // live_q holds s_ready low until the first edge after reset releases
    assign s_ready    = live_q && !fifo_full;
    assign wr_en      = s_valid && s_ready;
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

    assign room    = ({1'b0, ob_cnt_q} + {2'b00, inflight_q}) < 3'd2;
    assign issue   = (state_q == ST_ISSUE) && !fifo_empty && cell_ready && room;
    assign first   = (step_q == '0);
    assign hc_fire = issue && first;
    assign len_eff = (seq_len == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : seq_len;
    assign accept  = cell_valid && inflight_q;
    assign done    = (step_q == len_q);

    assign cell_x_valid = issue;
    assign cell_h_valid = hc_fire;
    assign cell_C_valid = hc_fire;
    assign cell_x       = issue ? head : '0;
    assign cell_h       = hc_fire ? h_init : '0;
    assign cell_C       = hc_fire ? C_init : '0;

    assign m_valid = (ob_cnt_q != 2'd0);
    assign m_y     = ob_y_q[ob_rd_q];
    assign m_C     = ob_c_q[ob_rd_q];
    assign m_last  = m_valid && ob_last_q[ob_rd_q];
    assign pop     = m_valid && m_ready;

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        len_d      = len_q;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_en ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d   = issue ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        ob_wr_d    = accept ? ~ob_wr_q : ob_wr_q;
        ob_rd_d    = pop ? ~ob_rd_q : ob_rd_q;
        ob_cnt_d   = ob_cnt_q;
        if (accept && !pop)
            ob_cnt_d = ob_cnt_q + 2'd1;
        else if (pop && !accept)
            ob_cnt_d = ob_cnt_q - 2'd1;

        case (state_q)
            // a sample written this cycle is visible in ISSUE next cycle
            ST_IDLE:
                if ((!fifo_empty || wr_en) && ob_cnt_q != 2'd2)
                    state_d = ST_ISSUE;
            ST_ISSUE:
                if (issue) begin
                    state_d    = ST_WAIT;
                    step_d     = step_q + 1'b1;
                    inflight_d = 1'b1;
                    if (first)
                        len_d = len_eff;
                end
            ST_WAIT:
                if (accept) begin
                    inflight_d = 1'b0;
                    if (done) begin
                        state_d = ST_IDLE;
                        step_d  = '0;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            fifo_mem[wr_ptr_q[AW-1:0]] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            live_q     <= 1'b0;
            step_q     <= '0;
            len_q      <= '0;
            inflight_q <= 1'b0;
            ob_cnt_q   <= '0;
            ob_wr_q    <= 1'b0;
            ob_rd_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                ob_y_q[i]    <= '0;
                ob_c_q[i]    <= '0;
                ob_last_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            live_q     <= 1'b1;
            step_q     <= step_d;
            len_q      <= len_d;
            inflight_q <= inflight_d;
            ob_cnt_q   <= ob_cnt_d;
            ob_wr_q    <= ob_wr_d;
            ob_rd_q    <= ob_rd_d;
            if (accept) begin
                ob_y_q[ob_wr_q]    <= cell_y;
                ob_c_q[ob_wr_q]    <= cell_C_out;
                ob_last_q[ob_wr_q] <= done;
            end
        end
    end
endmodule

// File: tb/tb_lstm_sequencer.sv
// Directed bench for lstm_sequencer with a 6-cycle LSTM cell model (y = x+h, C = x+C).
module tb_lstm_sequencer;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [LEN_W-1:0] seq_len = '0;
    logic [WIDTH-1:0] h_init = '0, C_init = '0, s_data = '0;
    logic             s_valid = 1'b0, m_ready = 1'b0, cell_en = 1'b0;
    logic             s_ready, cell_ready, cell_valid;
    logic [WIDTH-1:0] cell_x, cell_h, cell_C, cell_y, cell_C_out, m_y, m_C;
    logic             cell_x_valid, cell_h_valid, cell_C_valid, m_valid, m_last;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct { logic [WIDTH-1:0] x, h, c; logic hv, cv; int cyc; } iss_t;
    typedef struct { logic [WIDTH-1:0] y, c; logic last; int cyc; } out_t;
    iss_t iss_q[$];
    out_t out_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lstm_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .seq_len(seq_len), .h_init(h_init), .C_init(C_init),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .cell_ready(cell_ready),
        .cell_x(cell_x), .cell_h(cell_h), .cell_C(cell_C),
        .cell_x_valid(cell_x_valid), .cell_h_valid(cell_h_valid), .cell_C_valid(cell_C_valid),
        .cell_y(cell_y), .cell_C_out(cell_C_out), .cell_valid(cell_valid),
        .m_y(m_y), .m_C(m_C), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    // Cell model: busy for 6 cycles after accepting x, feeds back its own y/C
    logic             busy = 1'b0;
    int               cnt  = 0;
    logic [WIDTH-1:0] fb_h = '0, fb_c = '0, ry = '0, rc = '0;
    assign cell_ready = cell_en && !busy;
    assign cell_valid = busy && (cnt == 0);
    assign cell_y     = cell_valid ? ry : '0;
    assign cell_C_out = cell_valid ? rc : '0;

    always @(posedge clk) begin
        if (cell_x_valid && !busy) begin
            busy <= 1'b1;
            cnt  <= 5;
            ry   <= cell_x + (cell_h_valid ? cell_h : fb_h);
            rc   <= cell_x + (cell_C_valid ? cell_C : fb_c);
        end else if (busy) begin
            if (cnt == 0) begin
                busy <= 1'b0;
                fb_h <= ry;
                fb_c <= rc;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        iss_t ie;
        out_t oe;
        if (cell_x_valid) begin
            ie.x = cell_x; ie.h = cell_h; ie.c = cell_C;
            ie.hv = cell_h_valid; ie.cv = cell_C_valid; ie.cyc = cyc;
            iss_q.push_back(ie);
        end
        if (m_valid && m_ready) begin
            oe.y = m_y; oe.c = m_C; oe.last = m_last; oe.cyc = cyc;
            out_q.push_back(oe);
        end
        if (cell_valid) begin
            n_assert++;
            assert (cell_x_valid === 1'b0) else begin
                n_fail++;
                $error("FAIL issue_overlap: observed cell_x_valid=%b expected 0 at cycle %0d", cell_x_valid, cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, output int t);
        bit ok = 1'b0;
        t = -1;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            ok = s_ready;
            t  = cyc;
            tick();
        end
        s_valid = 1'b0;
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int i = 0; i < budget && out_q.size() < n; i++) tick();
        chk("wait_out_bound", 32'(out_q.size() >= n), 32'd1);
    endtask

    task automatic wait_iss(input int n, input int budget);
        for (int i = 0; i < budget && iss_q.size() < n; i++) tick();
        chk("wait_iss_bound", 32'(iss_q.size() >= n), 32'd1);
    endtask

    task automatic chk_out(input string tag, input int idx, input logic [WIDTH-1:0] y,
                           input logic [WIDTH-1:0] c, input logic last);
        if (out_q.size() > idx) begin
            chk({tag, "_y"}, 32'(out_q[idx].y), 32'(y));
            chk({tag, "_C"}, 32'(out_q[idx].c), 32'(c));
            chk({tag, "_last"}, 32'(out_q[idx].last), 32'(last));
        end else begin
            chk({tag, "_missing"}, 32'(out_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int t0, t;
        logic [WIDTH-1:0] xs [8];
        logic [WIDTH-1:0] ey;

        // Reset asserted asynchronously, before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_cell_x_valid", 32'(cell_x_valid), 32'd0);
        chk("rst_cell_h_valid", 32'(cell_h_valid), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_y", 32'(m_y), 32'd0);
        chk("rst_m_C", 32'(m_C), 32'd0);
        chk("rst_cell_x", 32'(cell_x), 32'd0);
        tick(); tick();
        rst = 1'b0;
        chk("rel_s_ready_low", 32'(s_ready), 32'd0);
        tick();
        chk("rel_s_ready_high", 32'(s_ready), 32'd1);

        // Basic 3-step sequence, latency and h/C strobes
        seq_len = 8'd3; h_init = 16'h0010; C_init = 16'h0020; m_ready = 1'b1; cell_en = 1'b1;
        push(16'h0100, t0); push(16'h0200, t); push(16'h0300, t);
        wait_out(3, 200);
        chk_out("t1_r0", 0, 16'h0110, 16'h0120, 1'b0);
        chk_out("t1_r1", 1, 16'h0310, 16'h0320, 1'b0);
        chk_out("t1_r2", 2, 16'h0610, 16'h0620, 1'b1);
        if (iss_q.size() >= 3 && out_q.size() >= 1) begin
            chk("t1_issue_lat", 32'(iss_q[0].cyc - t0), 32'd1);
            chk("t1_out_lat", 32'(out_q[0].cyc - t0), 32'd8);
            chk("t1_hv0", 32'({iss_q[0].hv, iss_q[0].cv}), 32'd3);
            chk("t1_h0", 32'({iss_q[0].h, iss_q[0].c}), 32'h0010_0020);
            chk("t1_hv1", 32'({iss_q[1].hv, iss_q[1].cv}), 32'd0);
            chk("t1_hv2", 32'({iss_q[2].hv, iss_q[2].cv}), 32'd0);
        end else begin
            chk("t1_issue_count", 32'(iss_q.size()), 32'd3);
        end

        // FIFO fill with cell stalled, overflow attempt, then drain
        iss_q.delete(); out_q.delete();
        cell_en = 1'b0; seq_len = 8'd2; h_init = '0; C_init = '0;
        for (int i = 0; i < DEPTH; i++) begin
            xs[i] = 16'h1000 + 16'(i);
            push(xs[i], t);
        end
        chk("t2_full_ready", 32'(s_ready), 32'd0);
        s_data = 16'h1FFF; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("t2_no_issue", 32'(iss_q.size()), 32'd0);
        cell_en = 1'b1;
        wait_out(DEPTH, 400);
        repeat (30) tick();
        chk("t2_count", 32'(out_q.size()), 32'(DEPTH));
        chk("t2_ready_back", 32'(s_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            ey = (i % 2 == 0) ? xs[i] : xs[i] + xs[i-1];
            chk_out($sformatf("t2_r%0d", i), i, ey, ey, (i % 2 == 1));
        end

        // Output backpressure: only two results held, issue stops
        iss_q.delete(); out_q.delete();
        m_ready = 1'b0; seq_len = 8'd4; h_init = 16'h0001; C_init = 16'h0002;
        push(16'h0100, t); push(16'h0200, t); push(16'h0300, t); push(16'h0400, t);
        repeat (40) tick();
        chk("t3_issues_held", 32'(iss_q.size()), 32'd2);
        chk("t3_m_valid", 32'(m_valid), 32'd1);
        chk("t3_m_y_head", 32'(m_y), 32'h0101);
        repeat (20) tick();
        chk("t3_issues_still", 32'(iss_q.size()), 32'd2);
        chk("t3_m_y_stable", 32'(m_y), 32'h0101);
        chk("t3_m_C_stable", 32'(m_C), 32'h0102);
        m_ready = 1'b1;
        wait_out(4, 200);
        chk_out("t3_r0", 0, 16'h0101, 16'h0102, 1'b0);
        chk_out("t3_r1", 1, 16'h0301, 16'h0302, 1'b0);
        chk_out("t3_r2", 2, 16'h0601, 16'h0602, 1'b0);
        chk_out("t3_r3", 3, 16'h0A01, 16'h0A02, 1'b1);

        // seq_len = 0 behaves as length 1
        iss_q.delete(); out_q.delete();
        seq_len = 8'd0; h_init = 16'h0005; C_init = 16'h0006;
        push(16'h0010, t); push(16'h0020, t);
        wait_out(2, 200);
        chk_out("t4_r0", 0, 16'h0015, 16'h0016, 1'b1);
        chk_out("t4_r1", 1, 16'h0025, 16'h0026, 1'b1);
        if (iss_q.size() >= 2)
            chk("t4_restrobe", 32'({iss_q[1].hv, iss_q[1].cv}), 32'd3);
        else
            chk("t4_issue_count", 32'(iss_q.size()), 32'd2);

        // Reset while waiting on the cell
        iss_q.delete(); out_q.delete();
        seq_len = 8'd2; h_init = 16'h0010; C_init = 16'h0020;
        push(16'h0100, t);
        wait_iss(1, 50);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_s_ready", 32'(s_ready), 32'd0);
        chk("t5_rst_m_valid", 32'(m_valid), 32'd0);
        chk("t5_rst_cx_valid", 32'(cell_x_valid), 32'd0);
        chk("t5_rst_data", 32'({m_y, m_C}), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        iss_q.delete(); out_q.delete();
        h_init = 16'h0030; C_init = 16'h0040;
        push(16'h0500, t); push(16'h0600, t);
        wait_out(2, 200);
        repeat (20) tick();
        chk("t5_count", 32'(out_q.size()), 32'd2);
        chk_out("t5_r0", 0, 16'h0530, 16'h0540, 1'b0);
        chk_out("t5_r1", 1, 16'h0B30, 16'h0B40, 1'b1);
        if (iss_q.size() >= 1)
            chk("t5_strobe", 32'({iss_q[0].hv, iss_q[0].cv}), 32'd3);
        else
            chk("t5_issue_count", 32'(iss_q.size()), 32'd1);

        // seq_len changed after the first issue has no effect on this sequence
        iss_q.delete(); out_q.delete();
        seq_len = 8'd2; h_init = '0; C_init = '0;
        push(16'h0100, t);
        wait_iss(1, 50);
        seq_len = 8'd5;
        push(16'h0200, t); push(16'h0300, t);
        wait_out(3, 300);
        chk_out("t6_r0", 0, 16'h0100, 16'h0100, 1'b0);
        chk_out("t6_r1", 1, 16'h0300, 16'h0300, 1'b1);
        chk_out("t6_r2", 2, 16'h0300, 16'h0300, 1'b0);
        if (iss_q.size() >= 3)
            chk("t6_new_seq_strobe", 32'(iss_q[2].hv), 32'd1);
        else
            chk("t6_issue_count", 32'(iss_q.size()), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
